irq_vector_router: RTL and testbench

Parametrised interrupt router with per-source level/edge modes and a vectored acknowledge handshake. It sits in the Dock between the tile slots and the CPU interrupt pins. Route entries are programmed over the shared 8-bit config bus in the window starting at IRQ_CFG_BASE. On a CPU vector-fetch cycle it selects the winning source for the acknowledged CPU line and drives a one-hot slot_ack to that tile.

---
 rtl/irq_vector_router_if.sv | 40 ++++
 rtl/irq_vector_router.sv | 186 ++++++++++++++++++
 tb/tb_irq_vector_router.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_vector_router_if.sv
// Signal bundle between the Dock interrupt router and its neighbours:
// the shared 8-bit config bus, tile request lines and the CPU interrupt /
// vector-fetch handshake. The router uses the slave modport; whatever drives
// the config bus, tiles and CPU side uses the master modport.
interface irq_vector_router_if #(
    parameter int NUM_SLOTS       = 3,
    parameter int NUM_TILE_INT_CH = 2,
    parameter int NUM_CPU_INT     = 2
);
    localparam int NUM_SRC = NUM_SLOTS * NUM_TILE_INT_CH;
    localparam int LW      = (NUM_CPU_INT > 1) ? $clog2(NUM_CPU_INT) : 1;
    localparam int SW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // config bus
    logic                   cfg_we;
    logic [7:0]             cfg_addr;
    logic [7:0]             cfg_wdata;
    // tile requests, index = slot*NUM_TILE_INT_CH + ch
    logic [NUM_SRC-1:0]     tile_int_req;
    // CPU side
    logic                   irq_vec_cycle;
    logic                   irq_ack;
    logic [LW-1:0]          ack_line;
    logic [NUM_CPU_INT-1:0] cpu_int;
    logic [NUM_SLOTS-1:0]   slot_ack;
    logic [SW-1:0]          ack_src;
    logic                   ack_valid;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, tile_int_req,
        output irq_vec_cycle, irq_ack, ack_line,
        input  cpu_int, slot_ack, ack_src, ack_valid
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, tile_int_req,
        input  irq_vec_cycle, irq_ack, ack_line,
        output cpu_int, slot_ack, ack_src, ack_valid
    );
endinterface

// File: rtl/irq_vector_router.sv
// Interrupt router: per-source level/edge capture, routing of sources onto
// CPU interrupt lines via config-bus programmed route entries, and a
// vectored acknowledge handshake that selects the lowest-index active source
// on the acknowledged line and reports it as a one-hot slot select.
module irq_vector_router #(
    parameter int         NUM_SLOTS       = 3,
    parameter int         NUM_TILE_INT_CH = 2,
    parameter int         NUM_CPU_INT     = 2,
    parameter logic [7:0] IRQ_CFG_BASE    = 8'hC0
) (
    input logic                clk,
    input logic                rst,
    irq_vector_router_if.slave bus
);
    localparam int NUM_SRC = NUM_SLOTS * NUM_TILE_INT_CH;
    localparam int SW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t state_reg, state_next;

    // Route entry fields. Reserved bits [5:4] have no effect and no readback
    // path, so only the functional fields are kept.
    logic [NUM_SRC-1:0] route_en_reg;
    logic [NUM_SRC-1:0] route_edge_reg;
    logic [3:0]         route_tgt_reg [NUM_SRC];

    logic [NUM_SRC-1:0] s1_reg, s2_reg, s2_d_reg;
    logic [NUM_SRC-1:0] pend_reg, pend_next;

    logic [NUM_SRC-1:0] cfg_sel;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] win_onehot;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SLOTS-1:0] win_slot;
    logic [SW-1:0]      win_idx;
    logic               win_found;
    logic               ack_take;
    logic               ack_exit;

    logic [NUM_CPU_INT-1:0] cpu_int_reg, cpu_int_next;
    logic [NUM_SLOTS-1:0]   slot_ack_reg;
    logic [SW-1:0]          ack_src_reg;
    logic                   ack_valid_reg;

    genvar gi;

    // Per-source address decode, active selection, ack candidacy and pend update.
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            localparam logic [7:0] ENTRY_ADDR = 8'(int'(IRQ_CFG_BASE) + gi);

            assign cfg_sel[gi] = bus.cfg_we && (bus.cfg_addr == ENTRY_ADDR);
            assign active[gi]  = route_edge_reg[gi] ? pend_reg[gi] : s2_reg[gi];
            assign cand[gi]    = route_en_reg[gi] && active[gi]
                                 && (route_tgt_reg[gi] == 4'(bus.ack_line));
            assign ack_clr[gi] = ack_take && win_onehot[gi] && route_edge_reg[gi];
            // A fresh rising edge beats any clear arriving in the same cycle.
            assign pend_next[gi] = (s2_reg[gi] & ~s2_d_reg[gi])
                                 | (pend_reg[gi] & ~cfg_sel[gi] & ~ack_clr[gi]);
        end
    endgenerate

    // Lowest-index candidate wins: isolate the least significant set bit.
    assign win_onehot = cand & (~cand + NUM_SRC'(1));
    assign win_found  = |cand;

    // Slot select is the OR of the winner bits belonging to each slot.
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign win_slot[gi] = |win_onehot[gi*NUM_TILE_INT_CH +: NUM_TILE_INT_CH];
        end
    endgenerate

    // Encode the one-hot winner into a source index (0 when there is none).
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (win_onehot[i]) win_idx = SW'(i);
        end
    end

    // Each CPU line is the OR of enabled, active sources that target it;
    // targets beyond NUM_CPU_INT never match and so drive nothing.
    always_comb begin
        cpu_int_next = '0;
        for (int l = 0; l < NUM_CPU_INT; l++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (route_en_reg[i] && active[i] && (route_tgt_reg[i] == 4'(l)))
                    cpu_int_next[l] = 1'b1;
            end
        end
    end

    // Route table: a write to an entry's address replaces the whole entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            route_en_reg   <= '0;
            route_edge_reg <= '0;
            for (int i = 0; i < NUM_SRC; i++) route_tgt_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cfg_sel[i]) begin
                    route_en_reg[i]   <= bus.cfg_wdata[7];
                    route_edge_reg[i] <= bus.cfg_wdata[6];
                    route_tgt_reg[i]  <= bus.cfg_wdata[3:0];
                end
            end
        end
    end

    // Two-flop synchroniser, previous-s2 copy for edge detect, and pend flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg   <= '0;
            s2_reg   <= '0;
            s2_d_reg <= '0;
            pend_reg <= '0;
        end else begin
            s1_reg   <= bus.tile_int_req;
            s2_reg   <= s1_reg;
            s2_d_reg <= s2_reg;
            pend_reg <= pend_next;
        end
    end

    // Registered CPU interrupt lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cpu_int_reg <= '0;
        else     cpu_int_reg <= cpu_int_next;
    end

    // Acknowledge FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Acknowledge FSM: take an ack only from IDLE, leave ACK when the fetch ends.
    always_comb begin
        state_next = state_reg;
        ack_take   = 1'b0;
        ack_exit   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.irq_vec_cycle && bus.irq_ack) begin
                    state_next = ST_ACK;
                    ack_take   = 1'b1;
                end
            end
            ST_ACK: begin
                if (!bus.irq_vec_cycle) begin
                    state_next = ST_IDLE;
                    ack_exit   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Latched vector-fetch outputs: captured on ack, held through ACK, cleared on exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_ack_reg  <= '0;
            ack_src_reg   <= '0;
            ack_valid_reg <= 1'b0;
        end else if (ack_take) begin
            slot_ack_reg  <= win_slot;
            ack_src_reg   <= win_idx;
            ack_valid_reg <= win_found;
        end else if (ack_exit) begin
            slot_ack_reg  <= '0;
            ack_src_reg   <= '0;
            ack_valid_reg <= 1'b0;
        end
    end

    assign bus.cpu_int   = cpu_int_reg;
    assign bus.slot_ack  = slot_ack_reg;
    assign bus.ack_src   = ack_src_reg;
    assign bus.ack_valid = ack_valid_reg;
endmodule

// File: tb/tb_irq_vector_router.sv
// Self-checking bench for irq_vector_router: directed scenarios plus a
// randomized route/request sweep checked against a rule-level model.
module tb_irq_vector_router;
    localparam int         NUM_SLOTS       = 3;
    localparam int         NUM_TILE_INT_CH = 2;
    localparam int         NUM_CPU_INT     = 2;
    localparam int         NUM_SRC         = NUM_SLOTS * NUM_TILE_INT_CH;
    localparam logic [7:0] BASE            = 8'hC0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    irq_vector_router_if #(
        .NUM_SLOTS(NUM_SLOTS), .NUM_TILE_INT_CH(NUM_TILE_INT_CH), .NUM_CPU_INT(NUM_CPU_INT)
    ) bus ();

    irq_vector_router #(
        .NUM_SLOTS(NUM_SLOTS), .NUM_TILE_INT_CH(NUM_TILE_INT_CH),
        .NUM_CPU_INT(NUM_CPU_INT), .IRQ_CFG_BASE(BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.cfg_we        = 1'b0;
        bus.cfg_addr      = 8'h00;
        bus.cfg_wdata     = 8'h00;
        bus.tile_int_req  = '0;
        bus.irq_vec_cycle = 1'b0;
        bus.irq_ack       = 1'b0;
        bus.ack_line      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [7:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic ack_start(input logic line);
        bus.ack_line      = line;
        bus.irq_vec_cycle = 1'b1;
        bus.irq_ack       = 1'b1;
        tick();
        bus.irq_ack       = 1'b0;
        $display("ack line=%0d -> slot_ack=%b ack_src=%0d ack_valid=%b",
                 line, bus.slot_ack, bus.ack_src, bus.ack_valid);
    endtask

    task automatic ack_end();
        bus.irq_vec_cycle = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.tile_int_req = '1;
        repeat (3) tick();
        n_cmp++;
        if (bus.cpu_int !== 2'b00 || bus.slot_ack !== 3'b000 || bus.ack_src !== 3'd0 || bus.ack_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: cpu_int=%b slot_ack=%b ack_src=%0d ack_valid=%b, required all 0",
                     bus.cpu_int, bus.slot_ack, bus.ack_src, bus.ack_valid);
        end
        rst = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if (bus.cpu_int !== 2'b00 || bus.slot_ack !== 3'b000 || bus.ack_src !== 3'd0 || bus.ack_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_noconfig: cpu_int=%b slot_ack=%b ack_src=%0d ack_valid=%b, required all 0",
                     bus.cpu_int, bus.slot_ack, bus.ack_src, bus.ack_valid);
        end
        bus.tile_int_req = '0;
    endtask

    task automatic test_level();
        logic [1:0] exp;
        do_reset();
        cfg_write(BASE + 8'd2, 8'h80);
        bus.tile_int_req[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp = (k < 2) ? 2'b00 : 2'b01;
            n_cmp++;
            if (bus.cpu_int !== exp) begin
                n_bad++;
                $display("FAIL level_assert edge%0d: cpu_int=%b required %b", k, bus.cpu_int, exp);
            end
        end
        bus.tile_int_req[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp = (k < 2) ? 2'b01 : 2'b00;
            n_cmp++;
            if (bus.cpu_int !== exp) begin
                n_bad++;
                $display("FAIL level_deassert edge%0d: cpu_int=%b required %b", k, bus.cpu_int, exp);
            end
        end
    endtask

    task automatic test_edge();
        do_reset();
        cfg_write(BASE + 8'd5, 8'hC1);
        bus.tile_int_req[5] = 1'b1;
        tick();
        bus.tile_int_req[5] = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (bus.cpu_int !== 2'b00) begin
            n_bad++;
            $display("FAIL edge_latency_early: cpu_int=%b required 00", bus.cpu_int);
        end
        tick();
        n_cmp++;
        if (bus.cpu_int !== 2'b10) begin
            n_bad++;
            $display("FAIL edge_latency: cpu_int=%b required 10", bus.cpu_int);
        end
        repeat (3) tick();
        n_cmp++;
        if (bus.cpu_int !== 2'b10) begin
            n_bad++;
            $display("FAIL edge_held: cpu_int=%b required 10", bus.cpu_int);
        end
        ack_start(1'b1);
        n_cmp++;
        if (bus.slot_ack !== 3'b100 || bus.ack_src !== 3'd5 || bus.ack_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL edge_ack: slot_ack=%b ack_src=%0d ack_valid=%b required 100/5/1",
                     bus.slot_ack, bus.ack_src, bus.ack_valid);
        end
        tick();
        n_cmp++;
        if (bus.cpu_int !== 2'b00 || bus.slot_ack !== 3'b100) begin
            n_bad++;
            $display("FAIL edge_after_ack: cpu_int=%b slot_ack=%b required 00/100", bus.cpu_int, bus.slot_ack);
        end
        ack_end();
        n_cmp++;
        if (bus.slot_ack !== 3'b000 || bus.ack_src !== 3'd0 || bus.ack_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL edge_ack_exit: slot_ack=%b ack_src=%0d ack_valid=%b required 0/0/0",
                     bus.slot_ack, bus.ack_src, bus.ack_valid);
        end
    endtask

    task automatic test_priority();
        do_reset();
        cfg_write(BASE + 8'd1, 8'hC0);
        cfg_write(BASE + 8'd4, 8'hC0);
        bus.tile_int_req[1] = 1'b1;
        bus.tile_int_req[4] = 1'b1;
        tick();
        bus.tile_int_req = '0;
        repeat (4) tick();
        n_cmp++;
        if (bus.cpu_int !== 2'b01) begin
            n_bad++;
            $display("FAIL prio_pending: cpu_int=%b required 01", bus.cpu_int);
        end
        ack_start(1'b0);
        n_cmp++;
        if (bus.ack_src !== 3'd1 || bus.slot_ack !== 3'b001 || bus.ack_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL prio_first: ack_src=%0d slot_ack=%b ack_valid=%b required 1/001/1",
                     bus.ack_src, bus.slot_ack, bus.ack_valid);
        end
        ack_end();
        ack_start(1'b0);
        n_cmp++;
        if (bus.ack_src !== 3'd4 || bus.slot_ack !== 3'b100 || bus.ack_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL prio_second: ack_src=%0d slot_ack=%b ack_valid=%b required 4/100/1",
                     bus.ack_src, bus.slot_ack, bus.ack_valid);
        end
        ack_end();
        tick();
        n_cmp++;
        if (bus.cpu_int !== 2'b00) begin
            n_bad++;
            $display("FAIL prio_drained: cpu_int=%b required 00", bus.cpu_int);
        end
    endtask

    task automatic test_spurious_ignored();
        do_reset();
        ack_start(1'b0);
        n_cmp++;
        if (bus.ack_valid !== 1'b0 || bus.slot_ack !== 3'b000 || bus.ack_src !== 3'd0) begin
            n_bad++;
            $display("FAIL spurious_ack: ack_valid=%b slot_ack=%b ack_src=%0d required 0/000/0",
                     bus.ack_valid, bus.slot_ack, bus.ack_src);
        end
        ack_end();
        bus.tile_int_req = '1;
        cfg_write(8'hBF, 8'h80);
        cfg_write(BASE + 8'd6, 8'h80);
        cfg_write(BASE + 8'd0, 8'h82);
        repeat (5) tick();
        n_cmp++;
        if (bus.cpu_int !== 2'b00) begin
            n_bad++;
            $display("FAIL ignored_writes: cpu_int=%b required 00", bus.cpu_int);
        end
        cfg_write(BASE + 8'd1, 8'h81);
        tick();
        n_cmp++;
        if (bus.cpu_int !== 2'b10) begin
            n_bad++;
            $display("FAIL cfg_latency: cpu_int=%b required 10", bus.cpu_int);
        end
        ack_start(1'b1);
        n_cmp++;
        if (bus.ack_src !== 3'd1 || bus.slot_ack !== 3'b001 || bus.ack_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL level_ack: ack_src=%0d slot_ack=%b ack_valid=%b required 1/001/1",
                     bus.ack_src, bus.slot_ack, bus.ack_valid);
        end
        ack_end();
        repeat (2) tick();
        n_cmp++;
        if (bus.cpu_int !== 2'b10) begin
            n_bad++;
            $display("FAIL level_after_ack: cpu_int=%b required 10", bus.cpu_int);
        end
        bus.tile_int_req = '0;
    endtask

    task automatic test_reset_during_ack();
        do_reset();
        cfg_write(BASE + 8'd3, 8'h81);
        bus.tile_int_req[3] = 1'b1;
        repeat (4) tick();
        ack_start(1'b1);
        n_cmp++;
        if (bus.ack_src !== 3'd3 || bus.slot_ack !== 3'b010 || bus.ack_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_ack: ack_src=%0d slot_ack=%b ack_valid=%b required 3/010/1",
                     bus.ack_src, bus.slot_ack, bus.ack_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.cpu_int !== 2'b00 || bus.slot_ack !== 3'b000 || bus.ack_src !== 3'd0 || bus.ack_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_ack: cpu_int=%b slot_ack=%b ack_src=%0d ack_valid=%b required all 0",
                     bus.cpu_int, bus.slot_ack, bus.ack_src, bus.ack_valid);
        end
        bus.irq_vec_cycle = 1'b0;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if (bus.cpu_int !== 2'b00) begin
            n_bad++;
            $display("FAIL route_cleared_by_reset: cpu_int=%b required 00", bus.cpu_int);
        end
        bus.tile_int_req = '0;
    endtask

    task automatic test_collision();
        do_reset();
        cfg_write(BASE + 8'd0, 8'hC0);
        bus.tile_int_req[0] = 1'b1;
        tick();
        bus.tile_int_req[0] = 1'b0;
        repeat (4) tick();
        // New request timed so its synchronised rising edge lands on the ack edge.
        bus.tile_int_req[0] = 1'b1;
        tick();
        tick();
        ack_start(1'b0);
        n_cmp++;
        if (bus.ack_src !== 3'd0 || bus.slot_ack !== 3'b001 || bus.ack_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL collision_ack: ack_src=%0d slot_ack=%b ack_valid=%b required 0/001/1",
                     bus.ack_src, bus.slot_ack, bus.ack_valid);
        end
        tick();
        tick();
        n_cmp++;
        if (bus.cpu_int !== 2'b01) begin
            n_bad++;
            $display("FAIL collision_set_wins: cpu_int=%b required 01", bus.cpu_int);
        end
        ack_end();
        ack_start(1'b0);
        n_cmp++;
        if (bus.ack_valid !== 1'b1 || bus.ack_src !== 3'd0) begin
            n_bad++;
            $display("FAIL collision_reack: ack_valid=%b ack_src=%0d required 1/0", bus.ack_valid, bus.ack_src);
        end
        ack_end();
        tick();
        n_cmp++;
        if (bus.cpu_int !== 2'b00) begin
            n_bad++;
            $display("FAIL collision_drained: cpu_int=%b required 00", bus.cpu_int);
        end
        bus.tile_int_req = '0;
    endtask

    // Random routes and request patterns; expectations come from the routing
    // rules: level sources are active while held, edge sources once pulsed
    // until served, and each ack serves the lowest enabled active source.
    task automatic test_random();
        logic [7:0] ent [NUM_SRC];
        int         pat [NUM_SRC];
        bit         act [NUM_SRC];
        logic [1:0] exp_int;
        logic [2:0] exp_slot;
        int         win;
        int         tgt;
        for (int it = 0; it < 24; it++) begin
            do_reset();
            for (int i = 0; i < NUM_SRC; i++) begin
                ent[i] = {1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom_range(0, 3))};
                pat[i] = int'($urandom_range(0, 2));
                cfg_write(BASE + 8'(i), ent[i]);
            end
            for (int i = 0; i < NUM_SRC; i++) bus.tile_int_req[i] = (pat[i] != 0);
            tick();
            for (int i = 0; i < NUM_SRC; i++) bus.tile_int_req[i] = (pat[i] == 2);
            repeat (5) tick();
            for (int i = 0; i < NUM_SRC; i++)
                act[i] = ent[i][6] ? (pat[i] != 0) : (pat[i] == 2);
            for (int r = 0; r < 3; r++) begin
                for (int l = 0; l < NUM_CPU_INT; l++) begin
                    exp_int = 2'b00;
                    for (int i = 0; i < NUM_SRC; i++) begin
                        tgt = int'(ent[i][3:0]);
                        if (ent[i][7] && act[i] && tgt < NUM_CPU_INT) exp_int[tgt] = 1'b1;
                    end
                    n_cmp++;
                    if (bus.cpu_int !== exp_int) begin
                        n_bad++;
                        $display("FAIL rand_cpu_int it%0d r%0d l%0d: cpu_int=%b required %b",
                                 it, r, l, bus.cpu_int, exp_int);
                    end
                    win = -1;
                    for (int i = NUM_SRC - 1; i >= 0; i--) begin
                        if (ent[i][7] && act[i] && int'(ent[i][3:0]) == l) win = i;
                    end
                    exp_slot = (win >= 0) ? 3'(1 << (win / NUM_TILE_INT_CH)) : 3'b000;
                    ack_start(1'(l));
                    n_cmp++;
                    if (bus.ack_valid !== (win >= 0) || bus.slot_ack !== exp_slot
                        || bus.ack_src !== ((win >= 0) ? 3'(win) : 3'd0)) begin
                        n_bad++;
                        $display("FAIL rand_ack it%0d r%0d l%0d: valid=%b slot=%b src=%0d required %b/%b/%0d",
                                 it, r, l, bus.ack_valid, bus.slot_ack, bus.ack_src,
                                 (win >= 0), exp_slot, (win >= 0) ? win : 0);
                    end
                    if (win >= 0 && ent[win][6]) act[win] = 1'b0;
                    ack_end();
                    tick();
                    tick();
                end
            end
        end
        bus.tile_int_req = '0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_level();
        test_edge();
        test_priority();
        test_spurious_ignored();
        test_reset_during_ack();
        test_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
